// File: rtl/writeback_store_if.sv
// dCache core-bus channel between the writeback stage (master) and the data cache (slave).
interface writeback_store_if;
    logic        reqcycOut;
    logic        reqackIn;
    logic [63:0] reqOut;
    logic [12:0] reqtagOut;
    logic        respcycIn;
    logic [63:0] respIn;
    logic        respackOut;

    modport master (
        output reqcycOut, reqOut, reqtagOut, respackOut,
        input  reqackIn, respcycIn, respIn
    );

    modport slave (
        input  reqcycOut, reqOut, reqtagOut, respackOut,
        output reqackIn, respcycIn, respIn
    );
endinterface

// File: rtl/writeback_store.sv
// Writeback stage: retires one instruction per cycle, commits register results and issues stores on the dCache bus.
// Macro WB_STORE_BUFFER_EN turns the store engine into a one-entry posted buffer so non-stores keep retiring.
module writeback_store #(
    parameter logic [12:0] STORE_TAG = 13'h1C00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              opcodeValidIn,
    input  logic              isMemorySuccessfulIn,
    input  logic [63:0]       currentRipIn,
    input  logic [3:0]        destRegIn,
    input  logic              destRegValidIn,
    input  logic [63:0]       destRegValueIn,
    input  logic [3:0]        destRegSpecialIn,
    input  logic              destRegSpecialValidIn,
    input  logic              didMemoryReadIn,
    input  logic [63:0]       memoryDataIn,
    input  logic              isMemoryAccessDestIn,
    input  logic [63:0]       memoryAddressDestIn,
    output logic              regWriteEnOut,
    output logic [3:0]        regWriteAddrOut,
    output logic [63:0]       regWriteDataOut,
    output logic              specialWriteEnOut,
    output logic [3:0]        specialWriteAddrOut,
    output logic [63:0]       lastRipOut,
    output logic              wbStallOut,
    output logic              storePendingOut,
    output logic [63:0]       storePendingAddrOut,
    output logic [63:0]       retiredCountOut,
    writeback_store_if.master dbus
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_acc;
    logic        w_store_acc;
    logic [63:0] w_req_nxt;
    logic [12:0] w_reqtag_nxt;
    logic [63:0] r_st_addr;
    logic [63:0] r_st_data;
    logic        w_unused_resp;

    // Response payload carries nothing the stage needs.
    assign w_unused_resp = ^dbus.respIn;

`ifdef WB_STORE_BUFFER_EN
    assign wbStallOut = (r_state != ST_IDLE) & opcodeValidIn & isMemorySuccessfulIn & isMemoryAccessDestIn;
`else
    assign wbStallOut = (r_state != ST_IDLE);
`endif

    assign w_acc               = opcodeValidIn & isMemorySuccessfulIn & ~wbStallOut;
    assign w_store_acc         = w_acc & isMemoryAccessDestIn;
    assign storePendingOut     = (r_state != ST_IDLE);
    assign storePendingAddrOut = r_st_addr;

    // Store engine state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Store engine next-state and next bus request.
    always_comb begin
        w_state_nxt  = r_state;
        w_req_nxt    = 64'd0;
        w_reqtag_nxt = 13'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_store_acc) w_state_nxt = ST_ADDR;
                else             w_state_nxt = ST_IDLE;
            end
            ST_ADDR: begin
                if (dbus.reqackIn) w_state_nxt = ST_DATA;
                else               w_state_nxt = ST_ADDR;
            end
            ST_DATA: begin
                if (dbus.reqackIn) w_state_nxt = ST_RESP;
                else               w_state_nxt = ST_DATA;
            end
            ST_RESP: begin
                if (dbus.respcycIn) w_state_nxt = ST_IDLE;
                else                w_state_nxt = ST_RESP;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        case (w_state_nxt)
            ST_ADDR: begin
                // ADDR is only entered from IDLE, where the address is not yet latched.
                w_req_nxt    = (r_state == ST_IDLE) ? memoryAddressDestIn : r_st_addr;
                w_reqtag_nxt = STORE_TAG;
            end
            ST_DATA: begin
                w_req_nxt    = r_st_data;
                w_reqtag_nxt = STORE_TAG;
            end
            default: begin
                w_req_nxt    = 64'd0;
                w_reqtag_nxt = 13'd0;
            end
        endcase
    end

    // Registered bus outputs; a reset mid-store drops the cycle immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbus.reqcycOut  <= 1'b0;
            dbus.reqOut     <= 64'd0;
            dbus.reqtagOut  <= 13'd0;
            dbus.respackOut <= 1'b0;
        end else begin
            dbus.reqcycOut  <= (w_state_nxt == ST_ADDR) || (w_state_nxt == ST_DATA);
            dbus.reqOut     <= w_req_nxt;
            dbus.reqtagOut  <= w_reqtag_nxt;
            dbus.respackOut <= (r_state == ST_RESP) && dbus.respcycIn;
        end
    end

    // Store address/data latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_st_addr <= 64'd0;
            r_st_data <= 64'd0;
        end else if (w_store_acc) begin
            r_st_addr <= memoryAddressDestIn;
            r_st_data <= destRegValueIn;
        end else begin
            r_st_addr <= r_st_addr;
            r_st_data <= r_st_data;
        end
    end

    // Register commit, retire counter and last RIP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regWriteEnOut       <= 1'b0;
            regWriteAddrOut     <= 4'd0;
            regWriteDataOut     <= 64'd0;
            specialWriteEnOut   <= 1'b0;
            specialWriteAddrOut <= 4'd0;
            lastRipOut          <= 64'd0;
            retiredCountOut     <= 64'd0;
        end else if (w_acc) begin
            retiredCountOut <= retiredCountOut + 64'd1;
            lastRipOut      <= currentRipIn;
            if (isMemoryAccessDestIn) begin
                regWriteEnOut     <= 1'b0;
                specialWriteEnOut <= 1'b0;
            end else begin
                regWriteEnOut       <= destRegValidIn;
                specialWriteEnOut   <= destRegSpecialValidIn;
                regWriteAddrOut     <= destRegIn;
                specialWriteAddrOut <= destRegSpecialIn;
                regWriteDataOut     <= didMemoryReadIn ? memoryDataIn : destRegValueIn;
            end
        end else begin
            regWriteEnOut     <= 1'b0;
            specialWriteEnOut <= 1'b0;
        end
    end

endmodule

// File: tb/tb_writeback_store.sv
// Self-checking bench for writeback_store: directed scenarios plus a randomized stream against a transaction-level model.
module tb_writeback_store;
    logic        clk;
    logic        reset;
    logic        opcodeValidIn, isMemorySuccessfulIn;
    logic [63:0] currentRipIn;
    logic [3:0]  destRegIn;
    logic        destRegValidIn;
    logic [63:0] destRegValueIn;
    logic [3:0]  destRegSpecialIn;
    logic        destRegSpecialValidIn;
    logic        didMemoryReadIn;
    logic [63:0] memoryDataIn;
    logic        isMemoryAccessDestIn;
    logic [63:0] memoryAddressDestIn;
    logic        regWriteEnOut;
    logic [3:0]  regWriteAddrOut;
    logic [63:0] regWriteDataOut;
    logic        specialWriteEnOut;
    logic [3:0]  specialWriteAddrOut;
    logic [63:0] lastRipOut;
    logic        wbStallOut;
    logic        storePendingOut;
    logic [63:0] storePendingAddrOut;
    logic [63:0] retiredCountOut;

    writeback_store_if dbus ();

    writeback_store dut (
        .clk(clk), .reset(reset),
        .opcodeValidIn(opcodeValidIn), .isMemorySuccessfulIn(isMemorySuccessfulIn),
        .currentRipIn(currentRipIn), .destRegIn(destRegIn), .destRegValidIn(destRegValidIn),
        .destRegValueIn(destRegValueIn), .destRegSpecialIn(destRegSpecialIn),
        .destRegSpecialValidIn(destRegSpecialValidIn), .didMemoryReadIn(didMemoryReadIn),
        .memoryDataIn(memoryDataIn), .isMemoryAccessDestIn(isMemoryAccessDestIn),
        .memoryAddressDestIn(memoryAddressDestIn), .regWriteEnOut(regWriteEnOut),
        .regWriteAddrOut(regWriteAddrOut), .regWriteDataOut(regWriteDataOut),
        .specialWriteEnOut(specialWriteEnOut), .specialWriteAddrOut(specialWriteAddrOut),
        .lastRipOut(lastRipOut), .wbStallOut(wbStallOut), .storePendingOut(storePendingOut),
        .storePendingAddrOut(storePendingAddrOut), .retiredCountOut(retiredCountOut),
        .dbus(dbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [63:0] val;
        logic        is_addr;
    } beat_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        opcodeValidIn = 1'b0; isMemorySuccessfulIn = 1'b0; currentRipIn = 64'd0;
        destRegIn = 4'd0; destRegValidIn = 1'b0; destRegValueIn = 64'd0;
        destRegSpecialIn = 4'd0; destRegSpecialValidIn = 1'b0;
        didMemoryReadIn = 1'b0; memoryDataIn = 64'd0;
        isMemoryAccessDestIn = 1'b0; memoryAddressDestIn = 64'd0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        dbus.reqackIn = 1'b0; dbus.respcycIn = 1'b0; dbus.respIn = 64'd0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic present(input logic st, input logic [3:0] rd, input logic [63:0] val,
                           input logic [63:0] addr, input logic [63:0] rip);
        clear_inputs();
        opcodeValidIn = 1'b1; isMemorySuccessfulIn = 1'b1;
        isMemoryAccessDestIn = st; destRegIn = rd; destRegValidIn = 1'b1;
        destRegValueIn = val; memoryAddressDestIn = addr; currentRipIn = rip;
    endtask

    // reference model state for the randomized phase
    beat_t       m_q[$];
    logic        m_wait;
    logic [63:0] m_count, m_rip, m_st_addr;
    logic        e_we, e_swe, e_respack;
    logic [3:0]  e_waddr, e_swaddr;
    logic [63:0] e_wdata;
    logic        busy, stall_exp, acc;

    initial begin
        // reset values
        clear_inputs();
        dbus.reqackIn = 1'b0; dbus.respcycIn = 1'b0; dbus.respIn = 64'd0;
        reset = 1'b0;
        #12;
        check("rst_we", regWriteEnOut, 64'd0);
        check("rst_reqcyc", dbus.reqcycOut, 64'd0);
        check("rst_count", retiredCountOut, 64'd0);
        check("rst_pending", storePendingOut, 64'd0);
        check("rst_stall", wbStallOut, 64'd0);
        check("rst_respack", dbus.respackOut, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // ALU op
        present(1'b0, 4'd3, 64'h1234, 64'd0, 64'h400);
        tick();
        check("alu_we", regWriteEnOut, 64'd1);
        check("alu_addr", regWriteAddrOut, 64'd3);
        check("alu_data", regWriteDataOut, 64'h1234);
        check("alu_count", retiredCountOut, 64'd1);
        check("alu_rip", lastRipOut, 64'h400);
        check("alu_swe", specialWriteEnOut, 64'd0);
        clear_inputs();
        tick();
        check("we_pulse", regWriteEnOut, 64'd0);

        // load with special-register destination
        present(1'b0, 4'd7, 64'h5, 64'd0, 64'h404);
        didMemoryReadIn = 1'b1; memoryDataIn = 64'hDEADBEEF;
        destRegSpecialValidIn = 1'b1; destRegSpecialIn = 4'd2;
        tick();
        check("ld_data", regWriteDataOut, 64'hDEADBEEF);
        check("ld_addr", regWriteAddrOut, 64'd7);
        check("ld_swe", specialWriteEnOut, 64'd1);
        check("ld_swaddr", specialWriteAddrOut, 64'd2);
        check("ld_count", retiredCountOut, 64'd2);

        // memory stage not done: nothing retires
        present(1'b0, 4'd9, 64'h77, 64'd0, 64'h408);
        isMemorySuccessfulIn = 1'b0;
        tick();
        tick();
        check("nsucc_we", regWriteEnOut, 64'd0);
        check("nsucc_count", retiredCountOut, 64'd2);
        check("nsucc_reqcyc", dbus.reqcycOut, 64'd0);
        check("nsucc_rip", lastRipOut, 64'h404);

        // store with late acks; k counts cycles after acceptance
        present(1'b1, 4'd4, 64'hAA, 64'h1000, 64'h40C);
        tick();
        clear_inputs();
        check("st_count", retiredCountOut, 64'd3);
        for (int k = 1; k <= 11; k++) begin
            check("st_reqcyc", dbus.reqcycOut, (k <= 6) ? 64'd1 : 64'd0);
            if (k <= 3) begin
                check("st_req_addr", dbus.reqOut, 64'h1000);
                check("st_tag", dbus.reqtagOut, 64'h1C00);
            end
            if (k >= 4 && k <= 6) check("st_req_data", dbus.reqOut, 64'hAA);
            check("st_respack", dbus.respackOut, (k == 10) ? 64'd1 : 64'd0);
            check("st_pending", storePendingOut, (k <= 9) ? 64'd1 : 64'd0);
            if (k <= 9) check("st_paddr", storePendingAddrOut, 64'h1000);
`ifdef WB_STORE_BUFFER_EN
            check("st_stall", wbStallOut, 64'd0);
`else
            check("st_stall", wbStallOut, (k <= 9) ? 64'd1 : 64'd0);
`endif
            check("st_we", regWriteEnOut, 64'd0);
            dbus.reqackIn  = (k == 3 || k == 6);
            dbus.respcycIn = (k == 9 || k == 2);
            tick();
        end
        dbus.reqackIn = 1'b0; dbus.respcycIn = 1'b0;
        check("st_count_end", retiredCountOut, 64'd3);

        // instructions presented behind a store, bus acking every cycle
        apply_reset();
        present(1'b1, 4'd0, 64'h55, 64'h2000, 64'h500);
        dbus.reqackIn = 1'b1; dbus.respcycIn = 1'b1;
        tick();
        present(1'b0, 4'd1, 64'h11, 64'd0, 64'h504);
`ifdef WB_STORE_BUFFER_EN
        #1;
        check("buf_stall_alu", wbStallOut, 64'd0);
        tick();
        check("buf_alu1_we", regWriteEnOut, 64'd1);
        check("buf_alu1_addr", regWriteAddrOut, 64'd1);
        check("buf_alu1_count", retiredCountOut, 64'd2);
        present(1'b0, 4'd2, 64'h22, 64'd0, 64'h508);
        tick();
        check("buf_alu2_we", regWriteEnOut, 64'd1);
        check("buf_alu2_addr", regWriteAddrOut, 64'd2);
        check("buf_alu2_count", retiredCountOut, 64'd3);
        present(1'b1, 4'd0, 64'h66, 64'h3000, 64'h50C);
        #1;
        check("buf_st2_stall", wbStallOut, 64'd1);
        tick();
        check("buf_respack", dbus.respackOut, 64'd1);
        check("buf_held_count", retiredCountOut, 64'd3);
        check("buf_idle_stall", wbStallOut, 64'd0);
        tick();
        check("buf_final_count", retiredCountOut, 64'd4);
        check("buf_st2_reqcyc", dbus.reqcycOut, 64'd1);
        check("buf_st2_req", dbus.reqOut, 64'h3000);
`else
        #1;
        check("blk_stall_alu", wbStallOut, 64'd1);
        tick();
        check("blk_held_we", regWriteEnOut, 64'd0);
        check("blk_held_count", retiredCountOut, 64'd1);
        tick();
        check("blk_stall_resp", wbStallOut, 64'd1);
        tick();
        check("blk_respack", dbus.respackOut, 64'd1);
        check("blk_idle_stall", wbStallOut, 64'd0);
        tick();
        check("blk_alu_we", regWriteEnOut, 64'd1);
        check("blk_alu_addr", regWriteAddrOut, 64'd1);
        check("blk_alu_count", retiredCountOut, 64'd2);
        check("blk_alu_rip", lastRipOut, 64'h504);
`endif

        // asynchronous reset in the middle of the data beat
        apply_reset();
        present(1'b1, 4'd0, 64'h99, 64'h4000, 64'h600);
        tick();
        clear_inputs();
        dbus.reqackIn = 1'b1;
        tick();
        dbus.reqackIn = 1'b0;
        check("mid_reqcyc_pre", dbus.reqcycOut, 64'd1);
        check("mid_req_data", dbus.reqOut, 64'h99);
        #2;
        reset = 1'b0;
        #1;
        check("mid_reqcyc_async", dbus.reqcycOut, 64'd0);
        check("mid_respack_async", dbus.respackOut, 64'd0);
        check("mid_pending_async", storePendingOut, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        check("mid_pending_after", storePendingOut, 64'd0);
        check("mid_count_after", retiredCountOut, 64'd0);
        check("mid_reqcyc_after", dbus.reqcycOut, 64'd0);
        check("mid_stall_after", wbStallOut, 64'd0);

        // randomized stream against the transaction model
        apply_reset();
        m_q.delete();
        m_wait = 1'b0; m_count = 64'd0; m_rip = 64'd0; m_st_addr = 64'd0;
        e_we = 1'b0; e_swe = 1'b0; e_respack = 1'b0;
        e_waddr = 4'd0; e_swaddr = 4'd0; e_wdata = 64'd0;
        for (int c = 0; c < 400; c++) begin
            check("rnd_we", regWriteEnOut, e_we);
            check("rnd_swe", specialWriteEnOut, e_swe);
            if (e_we) check("rnd_waddr", regWriteAddrOut, e_waddr);
            if (e_we || e_swe) check("rnd_wdata", regWriteDataOut, e_wdata);
            if (e_swe) check("rnd_swaddr", specialWriteAddrOut, e_swaddr);
            check("rnd_count", retiredCountOut, m_count);
            check("rnd_rip", lastRipOut, m_rip);
            check("rnd_reqcyc", dbus.reqcycOut, (m_q.size() != 0) ? 64'd1 : 64'd0);
            if (m_q.size() != 0) begin
                check("rnd_req", dbus.reqOut, m_q[0].val);
                if (m_q[0].is_addr) check("rnd_tag", dbus.reqtagOut, 64'h1C00);
            end
            check("rnd_respack", dbus.respackOut, e_respack);
            busy = (m_q.size() != 0) || m_wait;
            check("rnd_pending", storePendingOut, busy);
            if (busy) check("rnd_paddr", storePendingAddrOut, m_st_addr);

            opcodeValidIn         = ($urandom_range(99) < 70);
            isMemorySuccessfulIn  = ($urandom_range(99) < 80);
            isMemoryAccessDestIn  = ($urandom_range(99) < 25);
            currentRipIn          = {$urandom, $urandom};
            destRegIn             = 4'($urandom);
            destRegValidIn        = 1'($urandom);
            destRegValueIn        = {$urandom, $urandom};
            destRegSpecialIn      = 4'($urandom);
            destRegSpecialValidIn = 1'($urandom);
            didMemoryReadIn       = 1'($urandom);
            memoryDataIn          = {$urandom, $urandom};
            memoryAddressDestIn   = {$urandom, $urandom};
            dbus.reqackIn         = ($urandom_range(99) < 50);
            dbus.respcycIn        = ($urandom_range(99) < 30);
            dbus.respIn           = {$urandom, $urandom};
            #1;
`ifdef WB_STORE_BUFFER_EN
            stall_exp = busy && opcodeValidIn && isMemorySuccessfulIn && isMemoryAccessDestIn;
`else
            stall_exp = busy;
`endif
            check("rnd_stall", wbStallOut, stall_exp);
            acc = opcodeValidIn && isMemorySuccessfulIn && !stall_exp;

            e_respack = m_wait && dbus.respcycIn;
            if (e_respack) m_wait = 1'b0;
            if (m_q.size() != 0 && dbus.reqackIn) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_wait = 1'b1;
            end
            e_we = 1'b0; e_swe = 1'b0;
            if (acc) begin
                m_count = m_count + 64'd1;
                m_rip   = currentRipIn;
                if (isMemoryAccessDestIn) begin
                    m_q.push_back('{memoryAddressDestIn, 1'b1});
                    m_q.push_back('{destRegValueIn, 1'b0});
                    m_st_addr = memoryAddressDestIn;
                end else begin
                    e_we     = destRegValidIn;
                    e_swe    = destRegSpecialValidIn;
                    e_waddr  = destRegIn;
                    e_swaddr = destRegSpecialIn;
                    e_wdata  = didMemoryReadIn ? memoryDataIn : destRegValueIn;
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
